// File: rtl/multu_sequencer_if.sv
// multu_sequencer_if: request/response bundle between EX-stage control and the MULTU sequencer
interface multu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rdData;
  modport master (output start, funct, dataA, dataB, input busy, done, stall, hi, lo, rdData);
  modport slave  (input start, funct, dataA, dataB, output busy, done, stall, hi, lo, rdData);
endinterface

// File: rtl/multu_sequencer.sv
// multu_sequencer: iterative shift-add MULTU controller owning HI/LO; MULTU_EARLY_EXIT_EN ends once the multiplier runs out of set bits
module multu_sequencer #(
  parameter int          WIDTH       = 32,
  parameter int          CNT_W       = 6,
  parameter logic [5:0]  FUNCT_MULTU = 6'b011001,
  parameter logic [5:0]  FUNCT_MFHI  = 6'b010000,
  parameter logic [5:0]  FUNCT_MFLO  = 6'b010010
) (
  input logic               clk,
  input logic               reset,
  multu_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNext;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               isReq;
  logic               finish;
  assign isReq    = bus.funct == FUNCT_MULTU || bus.funct == FUNCT_MFHI || bus.funct == FUNCT_MFLO;
  assign accept   = bus.start && bus.funct == FUNCT_MULTU && state != RUN;
  assign prodNext = mplier[0] ? prod + mcand : prod;
`ifdef MULTU_EARLY_EXIT_EN
  assign finish   = (mplier >> 1) == '0 || cnt == CNT_W'(WIDTH - 1);
`else
  assign finish   = cnt == CNT_W'(WIDTH - 1);
`endif
  assign bus.stall  = state == RUN && bus.start && isReq;
  assign bus.rdData = bus.funct == FUNCT_MFHI ? bus.hi : bus.funct == FUNCT_MFLO ? bus.lo : '0;
  // Sequencer: accept a MULTU, iterate one multiplier bit per cycle, commit HI/LO with a one-cycle done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        mcand    <= {{WIDTH{1'b0}}, bus.dataA};
        mplier   <= bus.dataB;
        prod     <= '0;
        cnt      <= '0;
        state    <= RUN;
        bus.busy <= 1'b1;
      end else if (state == RUN) begin
        prod   <= prodNext;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (finish) begin
          {bus.hi, bus.lo} <= prodNext;
          state            <= DONE;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
